uart_cmd_tx: RTL

//  Host-side sender for the 16-bit command link: takes one 16-bit command and

---
 rtl/uart_cmd_tx_if.sv | 12 +
 rtl/uart_cmd_tx.sv | 106 ++++++++++
 2 files changed

// File: rtl/uart_cmd_tx_if.sv
// Command-sender handshake bundle: request/command from the host, status and
// serial line back from the sender.
interface uart_cmd_tx_if;
  logic        snd_cmd;
  logic [15:0] cmd;
  logic        busy;
  logic        cmd_sent;
  logic        TX;

  modport master (output snd_cmd, cmd, input busy, cmd_sent, TX);
  modport slave  (input snd_cmd, cmd, output busy, cmd_sent, TX);
endinterface

// File: rtl/uart_cmd_tx.sv
// uart_cmd_tx: sends one 16-bit command as two back-to-back UART frames,
// high byte first. Each bit is held BAUD_DIV clocks.
// Optional feature macro UART_CMD_TX_PARITY_EN: 8E1 frames (even parity bit
// between d7 and stop); otherwise plain 8N1.
module uart_cmd_tx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic         clk,
  input  logic         rst,
  uart_cmd_tx_if.slave bus
);

`ifdef UART_CMD_TX_PARITY_EN
  localparam int FRAME_W = 11;
`else
  localparam int FRAME_W = 10;
`endif
  localparam int             CW        = ($clog2(BAUD_DIV) > 12) ? $clog2(BAUD_DIV) : 12;
  localparam logic [CW-1:0]  BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [3:0]     BIT_LAST  = 4'(FRAME_W - 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        baud_cnt;
  logic [3:0]           bit_cnt;
  logic [FRAME_W-1:0]   shreg;
  logic [15:0]          cmd_q;
  logic                 busy_q, sent_q;
  logic                 accept, bit_end, byte_end;

  // Frame laid out LSB-first on the line: start bit in bit 0, stop bit on top.
  function automatic logic [FRAME_W-1:0] frame(input logic [7:0] b);
`ifdef UART_CMD_TX_PARITY_EN
    frame = {1'b1, ^b, b, 1'b0};
`else
    frame = {1'b1, b, 1'b0};
`endif
  endfunction

  assign bit_end  = (baud_cnt == BAUD_LAST);
  assign byte_end = bit_end && (bit_cnt == BIT_LAST);

  // Next-state logic; snd_cmd is only honoured in IDLE.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (bus.snd_cmd) begin
        accept    = 1'b1;
        state_nxt = HIGH;
      end
      HIGH:    if (byte_end) state_nxt = LOW;
      LOW:     if (byte_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Baud timer, bit counter and shifter; shifting in 1s keeps the line idle-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '1;
      cmd_q    <= '0;
      busy_q   <= 1'b0;
      sent_q   <= 1'b0;
    end else if (accept) begin
      cmd_q    <= bus.cmd;
      shreg    <= frame(bus.cmd[15:8]);
      baud_cnt <= '0;
      bit_cnt  <= '0;
      busy_q   <= 1'b1;
      sent_q   <= 1'b0;
    end else if (state != IDLE) begin
      if (byte_end) begin
        baud_cnt <= '0;
        bit_cnt  <= '0;
        if (state == HIGH) begin
          shreg <= frame(cmd_q[7:0]);   // low byte starts with no gap
        end else begin
          shreg  <= '1;
          busy_q <= 1'b0;
          sent_q <= 1'b1;
        end
      end else if (bit_end) begin
        baud_cnt <= '0;
        bit_cnt  <= bit_cnt + 4'd1;
        shreg    <= {1'b1, shreg[FRAME_W-1:1]};
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

  assign bus.TX       = shreg[0];
  assign bus.busy     = busy_q;
  assign bus.cmd_sent = sent_q;

endmodule
